io_ready_gen: RTL and testbench
===============================

Name: io_ready_gen

Overview:
- Per-port I/O handshake stage that sits directly upstream of the Controller and drives its IO_ready input.
- Holds one input buffer and one output buffer per I/O port, each with a full/empty flag.
- Each cycle it checks whether the instruction's I/O read and write can complete, and commits them only if both can.
- When an access cannot complete, io_ready goes low and the Controller re-issues the thread's previous PC.

Parameters:
- WORD_WIDTH, 36, data width of each port buffer.
- PORT_COUNT, 4, number of I/O ports (input and output side each).
- PORT_ADDR_WIDTH, 2, index width; must be at least clog2(PORT_COUNT).

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- rd_en  in  1  current instruction reads an I/O input port.
- rd_port  in  PORT_ADDR_WIDTH  input port read by the instruction.
- wr_en  in  1  current instruction writes an I/O output port.
- wr_port  in  PORT_ADDR_WIDTH  output port written by the instruction.
- wr_data  in  WORD_WIDTH  data for the output port.
- io_ready  out  1  registered; high means this instruction's I/O committed.
- rd_data  out  WORD_WIDTH  registered data from the read port.
- ext_in_wren  in  PORT_COUNT  external producer write strobe, one bit per port.
- ext_in_data  in  PORT_COUNT*WORD_WIDTH  external producer data, port p at bits [p*WORD_WIDTH +: WORD_WIDTH].
- ext_in_ready  out  PORT_COUNT  equals ~in_full (combinational from flags).
- ext_out_valid  out  PORT_COUNT  equals out_full.
- ext_out_data  out  PORT_COUNT*WORD_WIDTH  output buffers, same packing as ext_in_data.
- ext_out_ack  in  PORT_COUNT  external consumer accept strobe.

Behaviour:
- Reset (async assert, sync release):
  - All in_full and out_full flags = 0; all buffers = 0.
  - io_ready = 1; rd_data = 0.
- Ready term, combinational from flags at cycle N:
  - rd_ok = !rd_en | in_full[rd_port]
  - wr_ok = !wr_en | !out_full[wr_port]
  - ready = rd_ok & wr_ok
- Latency: io_ready is ready registered at edge N+1, aligned with the Controller's one-cycle pipelining of IO_ready.
- All-or-nothing commit at edge N+1, only if ready:
  - If rd_en: in_full[rd_port] is cleared and rd_data <= in_buf[rd_port].
  - If wr_en: out_buf[wr_port] <= wr_data and out_full[wr_port] is set.
  - If ready = 0: neither access commits, no flag changes, and rd_data holds its value.
- External input side: when ext_in_wren[p] and !in_full[p], in_buf[p] loads and in_full[p] sets. A write to a full port is ignored (producer must honour ext_in_ready).
- External output side: when ext_out_ack[p] and out_full[p], out_full[p] clears. An ack while empty is ignored.
- Same-cycle collisions are decided on pre-edge flag values:
  - Thread read and external write on the same full port: the read commits and clears the flag; the external write is rejected because ext_in_ready was low.
  - Thread write and external ack on the same full port: the write is not ready (io_ready = 0); the ack clears the flag. A retry on the thread's next turn succeeds.
- rd_port and wr_port may be equal; they address independent buffers.
- rd_en = wr_en = 0: io_ready = 1 next cycle.
- Out-of-range port index (>= PORT_COUNT): treated as not ready; no commit.
- Reset asserted mid-operation: pending buffered data is discarded, flags cleared, io_ready forced to 1.

Optional Feature:
- Macro: IO_READY_GEN_STALL_COUNT_EN.
- Enabled:
  - Adds output stall_count, 32 bits, reset 0.
  - Increments at the same edge io_ready is registered low.
  - Saturates at all-ones.
- Disabled: port and counter are absent; no other behaviour changes.

Decomposition:
- Shared package holds:
  - the port-index width helper (clog2);
  - the localparam for stall counter width (32);
  - the flattened-bus slice convention for port data.
- One sub-module, io_port_slot, generated PORT_COUNT times. Each instance holds:
  - one in_buf/in_full pair and one out_buf/out_full pair;
  - its external handshake logic;
  - commit-enable inputs from the top.
- The top does port selection, the ready term, and the registered io_ready/rd_data.

Test Plan:
- After reset, rd_en=1 rd_port=2 with nothing loaded -> io_ready=0 next cycle; rd_data stays 0; ext_in_ready = 4'b1111.
- ext_in_wren[2] with data 0x123, then rd_en=1 rd_port=2 -> io_ready=1, rd_data=0x123, ext_in_ready[2] returns to 1.
- wr_en=1 wr_port=1 wr_data=0xABC twice with no ack -> first io_ready=1 and ext_out_valid[1]=1 with data 0xABC; second io_ready=0 with data unchanged.
- rd_en on full port 0 plus wr_en on full port 3 -> io_ready=0; in_full[0] stays set; rd_data unchanged (all-or-nothing).
- Same cycle: ext_in_wren[0]=1 with data 0x55 while the thread reads full port 0 holding 0x11 -> rd_data=0x11; 0x55 dropped; in_full[0]=0.
- With IO_READY_GEN_STALL_COUNT_EN defined: 5 stalled cycles -> stall_count=5; assert reset_n=0 mid-stall -> stall_count=0, io_ready=1, all flags 0.

Source files
------------

// File: rtl/io_ready_gen_pkg.sv
// rtl/io_ready_gen_pkg.sv - shared widths and bus-slicing helpers for io_ready_gen
package io_ready_gen_pkg;

   localparam int STALL_COUNT_WIDTH = 32;

   // Minimum index width able to address count ports
   function automatic int port_idx_width(input int count);
      return (count <= 1) ? 1 : $clog2(count);
   endfunction

   // Port p of a flattened data bus lives at [word_lsb(p, w) +: w]
   function automatic int word_lsb(input int port, input int width);
      return port * width;
   endfunction

endpackage

// File: rtl/io_port_slot.sv
// rtl/io_port_slot.sv - one I/O port: input buffer/flag and output buffer/flag with external handshakes
module io_port_slot
#(
   parameter int WORD_WIDTH = 36
)
(
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  ext_in_wren,
   input  logic [WORD_WIDTH-1:0] ext_in_data,
   input  logic                  ext_out_ack,
   input  logic                  rd_commit,
   input  logic                  wr_commit,
   input  logic [WORD_WIDTH-1:0] wr_data,
   output logic                  in_full,
   output logic [WORD_WIDTH-1:0] in_buf,
   output logic                  out_full,
   output logic [WORD_WIDTH-1:0] out_buf
);

   // Input side: thread read drains the slot; producer fills it only while empty
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         in_full <= 1'b0;
         in_buf  <= '0;
      end else if (rd_commit) begin
         in_full <= 1'b0;
      end else if (ext_in_wren && !in_full) begin
         in_full <= 1'b1;
         in_buf  <= ext_in_data;
      end
   end

   // Output side: thread write fills the slot only while empty; consumer ack drains it
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         out_full <= 1'b0;
         out_buf  <= '0;
      end else if (wr_commit) begin
         out_full <= 1'b1;
         out_buf  <= wr_data;
      end else if (ext_out_ack && out_full) begin
         out_full <= 1'b0;
      end
   end

endmodule

// File: rtl/io_ready_gen.sv
// rtl/io_ready_gen.sv - per-port I/O handshake stage producing IO_ready; optional IO_READY_GEN_STALL_COUNT_EN adds stall_count
module io_ready_gen
   import io_ready_gen_pkg::*;
#(
   parameter int WORD_WIDTH      = 36,
   parameter int PORT_COUNT      = 4,
   parameter int PORT_ADDR_WIDTH = 2
)
(
   input  logic                             clock,
   input  logic                             reset_n,
   input  logic                             rd_en,
   input  logic [PORT_ADDR_WIDTH-1:0]       rd_port,
   input  logic                             wr_en,
   input  logic [PORT_ADDR_WIDTH-1:0]       wr_port,
   input  logic [WORD_WIDTH-1:0]            wr_data,
   output logic                             io_ready,
   output logic [WORD_WIDTH-1:0]            rd_data,
   input  logic [PORT_COUNT-1:0]            ext_in_wren,
   input  logic [PORT_COUNT*WORD_WIDTH-1:0] ext_in_data,
   output logic [PORT_COUNT-1:0]            ext_in_ready,
   output logic [PORT_COUNT-1:0]            ext_out_valid,
   output logic [PORT_COUNT*WORD_WIDTH-1:0] ext_out_data,
   input  logic [PORT_COUNT-1:0]            ext_out_ack
`ifdef IO_READY_GEN_STALL_COUNT_EN
   ,
   output logic [STALL_COUNT_WIDTH-1:0]     stall_count
`endif
);

   // Every encodable index gets an entry; indices without a real port read as not ready
   localparam int IDX_COUNT = 1 << PORT_ADDR_WIDTH;

   logic [PORT_COUNT-1:0] in_full;
   logic [PORT_COUNT-1:0] out_full;
   logic [WORD_WIDTH-1:0] in_buf [PORT_COUNT];
   logic [IDX_COUNT-1:0]  in_avail_idx;
   logic [IDX_COUNT-1:0]  out_free_idx;
   logic [WORD_WIDTH-1:0] in_buf_idx [IDX_COUNT];
   logic                  rd_ok;
   logic                  wr_ok;
   logic                  ready;

   assign ext_in_ready  = ~in_full;
   assign ext_out_valid = out_full;

   for (genvar g = 0; g < IDX_COUNT; g++) begin : g_idx
      if (g < PORT_COUNT) begin : g_real
         assign in_avail_idx[g] = in_full[g];
         assign out_free_idx[g] = ~out_full[g];
         assign in_buf_idx[g]   = in_buf[g];
      end else begin : g_pad
         assign in_avail_idx[g] = 1'b0;
         assign out_free_idx[g] = 1'b0;
         assign in_buf_idx[g]   = '0;
      end
   end

   // Both accesses must be able to complete on pre-edge flags, or neither commits
   assign rd_ok = !rd_en || in_avail_idx[rd_port];
   assign wr_ok = !wr_en || out_free_idx[wr_port];
   assign ready = rd_ok && wr_ok;

   for (genvar p = 0; p < PORT_COUNT; p++) begin : g_slot
      io_port_slot #(
         .WORD_WIDTH (WORD_WIDTH)
      ) u_slot (
         .clock       (clock),
         .reset_n     (reset_n),
         .ext_in_wren (ext_in_wren[p]),
         .ext_in_data (ext_in_data[word_lsb(p, WORD_WIDTH) +: WORD_WIDTH]),
         .ext_out_ack (ext_out_ack[p]),
         .rd_commit   (ready && rd_en && (rd_port == PORT_ADDR_WIDTH'(p))),
         .wr_commit   (ready && wr_en && (wr_port == PORT_ADDR_WIDTH'(p))),
         .wr_data     (wr_data),
         .in_full     (in_full[p]),
         .in_buf      (in_buf[p]),
         .out_full    (out_full[p]),
         .out_buf     (ext_out_data[word_lsb(p, WORD_WIDTH) +: WORD_WIDTH])
      );
   end

   // Register the ready term for the Controller and capture read data on commit
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         io_ready <= 1'b1;
         rd_data  <= '0;
      end else begin
         io_ready <= ready;
         if (ready && rd_en) begin
            rd_data <= in_buf_idx[rd_port];
         end
      end
   end

`ifdef IO_READY_GEN_STALL_COUNT_EN
   // Count cycles registered as stalls, holding at all-ones
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         stall_count <= '0;
      end else if (!ready && (stall_count != '1)) begin
         stall_count <= stall_count + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_io_ready_gen.sv
// tb/tb_io_ready_gen.sv - directed self-checking bench for io_ready_gen
module tb_io_ready_gen;

   localparam int W  = 36;
   localparam int PC = 4;
   localparam int AW = 2;

   logic            clock = 1'b0;
   logic            reset_n;
   logic            rd_en;
   logic [AW-1:0]   rd_port;
   logic            wr_en;
   logic [AW-1:0]   wr_port;
   logic [W-1:0]    wr_data;
   logic            io_ready;
   logic [W-1:0]    rd_data;
   logic [PC-1:0]   ext_in_wren;
   logic [PC*W-1:0] ext_in_data;
   logic [PC-1:0]   ext_in_ready;
   logic [PC-1:0]   ext_out_valid;
   logic [PC*W-1:0] ext_out_data;
   logic [PC-1:0]   ext_out_ack;
`ifdef IO_READY_GEN_STALL_COUNT_EN
   logic [31:0]     stall_count;
`endif

   int total = 0;
   int fails = 0;

   always #5 clock = ~clock;

   io_ready_gen #(
      .WORD_WIDTH      (W),
      .PORT_COUNT      (PC),
      .PORT_ADDR_WIDTH (AW)
   ) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .rd_en         (rd_en),
      .rd_port       (rd_port),
      .wr_en         (wr_en),
      .wr_port       (wr_port),
      .wr_data       (wr_data),
      .io_ready      (io_ready),
      .rd_data       (rd_data),
      .ext_in_wren   (ext_in_wren),
      .ext_in_data   (ext_in_data),
      .ext_in_ready  (ext_in_ready),
      .ext_out_valid (ext_out_valid),
      .ext_out_data  (ext_out_data),
      .ext_out_ack   (ext_out_ack)
`ifdef IO_READY_GEN_STALL_COUNT_EN
      ,
      .stall_count   (stall_count)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Apply the current inputs across one rising edge, then sample 1ns later
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      rd_en = 1'b0; wr_en = 1'b0; ext_in_wren = '0; ext_out_ack = '0;
   endtask

   function automatic logic [W-1:0] out_word(input int p);
      return ext_out_data[p*W +: W];
   endfunction

   initial begin
      reset_n = 1'b0;
      rd_port = '0; wr_port = '0; wr_data = '0; ext_in_data = '0;
      idle();
      step();
      step();
      chk("reset_io_ready", 64'(io_ready), 64'h1);
      chk("reset_rd_data", 64'(rd_data), 64'h0);
      chk("reset_in_ready", 64'(ext_in_ready), 64'hF);
      chk("reset_out_valid", 64'(ext_out_valid), 64'h0);
      reset_n = 1'b1;
      step();

`ifdef IO_READY_GEN_STALL_COUNT_EN
      rd_en = 1'b1; rd_port = 2'd2;
      repeat (5) step();
      chk("stall_count_5", 64'(stall_count), 64'd5);
      #2 reset_n = 1'b0;
      #1;
      chk("stall_reset_count", 64'(stall_count), 64'd0);
      chk("stall_reset_ready", 64'(io_ready), 64'h1);
      chk("stall_reset_flags", 64'({ext_in_ready, ext_out_valid}), 64'hF0);
      step();
      reset_n = 1'b1;
      idle();
      step();
`endif

      // Read of an empty port stalls
      rd_en = 1'b1; rd_port = 2'd2;
      step();
      chk("empty_rd_ready", 64'(io_ready), 64'h0);
      chk("empty_rd_data", 64'(rd_data), 64'h0);
      chk("empty_in_ready", 64'(ext_in_ready), 64'hF);
      idle();

      // Producer loads port 2, then thread reads it
      ext_in_wren = 4'b0100; ext_in_data[2*W +: W] = 36'h123;
      step();
      chk("load2_in_ready", 64'(ext_in_ready), 64'hB);
      idle();
      rd_en = 1'b1; rd_port = 2'd2;
      step();
      chk("rd2_ready", 64'(io_ready), 64'h1);
      chk("rd2_data", 64'(rd_data), 64'h123);
      chk("rd2_in_ready", 64'(ext_in_ready), 64'hF);
      idle();

      // Two writes to port 1 without ack
      wr_en = 1'b1; wr_port = 2'd1; wr_data = 36'hABC;
      step();
      chk("wr1_ready", 64'(io_ready), 64'h1);
      chk("wr1_valid", 64'(ext_out_valid), 64'h2);
      chk("wr1_data", 64'(out_word(1)), 64'hABC);
      wr_data = 36'hDEF;
      step();
      chk("wr1_again_ready", 64'(io_ready), 64'h0);
      chk("wr1_again_data", 64'(out_word(1)), 64'hABC);
      idle();
      step();
      chk("idle_ready", 64'(io_ready), 64'h1);

      // Fill input port 0 and output port 3 together
      ext_in_wren = 4'b0001; ext_in_data[0 +: W] = 36'h11;
      wr_en = 1'b1; wr_port = 2'd3; wr_data = 36'h333;
      step();
      chk("fill_ready", 64'(io_ready), 64'h1);
      chk("fill_valid", 64'(ext_out_valid), 64'hA);
      idle();

      // All-or-nothing: read ok, write blocked
      rd_en = 1'b1; rd_port = 2'd0;
      wr_en = 1'b1; wr_port = 2'd3; wr_data = 36'h444;
      step();
      chk("aon_ready", 64'(io_ready), 64'h0);
      chk("aon_in_full0", 64'(ext_in_ready[0]), 64'h0);
      chk("aon_rd_data", 64'(rd_data), 64'h123);
      chk("aon_out3", 64'(out_word(3)), 64'h333);
      idle();

      // Thread read beats a same-cycle producer write on a full port
      rd_en = 1'b1; rd_port = 2'd0;
      ext_in_wren = 4'b0001; ext_in_data[0 +: W] = 36'h55;
      step();
      chk("coll_rd_ready", 64'(io_ready), 64'h1);
      chk("coll_rd_data", 64'(rd_data), 64'h11);
      chk("coll_in_ready0", 64'(ext_in_ready[0]), 64'h1);
      ext_in_wren = '0;
      step();
      chk("coll_dropped_ready", 64'(io_ready), 64'h0);
      chk("coll_dropped_data", 64'(rd_data), 64'h11);
      idle();

      // Thread write vs consumer ack on a full port, then retry
      wr_en = 1'b1; wr_port = 2'd3; wr_data = 36'h777;
      ext_out_ack = 4'b1000;
      step();
      chk("ack_coll_ready", 64'(io_ready), 64'h0);
      chk("ack_coll_valid", 64'(ext_out_valid), 64'h2);
      ext_out_ack = '0;
      step();
      chk("retry_ready", 64'(io_ready), 64'h1);
      chk("retry_valid", 64'(ext_out_valid), 64'hA);
      chk("retry_data", 64'(out_word(3)), 64'h777);
      idle();

      // Same index for read and write addresses independent buffers
      ext_out_ack = 4'b0010;
      ext_in_wren = 4'b0010; ext_in_data[1*W +: W] = 36'h9;
      step();
      chk("same_prep_valid", 64'(ext_out_valid), 64'h8);
      chk("same_prep_in_ready", 64'(ext_in_ready), 64'hD);
      idle();
      rd_en = 1'b1; rd_port = 2'd1;
      wr_en = 1'b1; wr_port = 2'd1; wr_data = 36'hAA;
      step();
      chk("same_ready", 64'(io_ready), 64'h1);
      chk("same_rd_data", 64'(rd_data), 64'h9);
      chk("same_out_data", 64'(out_word(1)), 64'hAA);
      chk("same_flags", 64'({ext_in_ready, ext_out_valid}), 64'hFA);
      idle();

      // Ack on an empty port is ignored
      ext_out_ack = 4'b0100;
      step();
      chk("ack_empty_valid", 64'(ext_out_valid), 64'hA);
      idle();

      // Asynchronous reset in the middle of a stall
      wr_en = 1'b1; wr_port = 2'd3; wr_data = 36'h1;
      step();
      chk("pre_reset_stall", 64'(io_ready), 64'h0);
      #2 reset_n = 1'b0;
      #1;
      chk("mid_reset_ready", 64'(io_ready), 64'h1);
      chk("mid_reset_flags", 64'({ext_in_ready, ext_out_valid}), 64'hF0);
      chk("mid_reset_out_data", 64'(ext_out_data[63:0]), 64'h0);
      chk("mid_reset_rd_data", 64'(rd_data), 64'h0);
`ifdef IO_READY_GEN_STALL_COUNT_EN
      chk("mid_reset_stall_count", 64'(stall_count), 64'h0);
`endif
      step();
      idle();
      reset_n = 1'b1;
      step();

      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end

endmodule
